// File: rtl/processor_jtag_bridge_fifo.sv
// Buffered bridge from the processor output port to a JTAG UART Avalon-MM slave.
// Processor strobes are queued in a small FIFO. A three-state sequencer then
// drains the queue: it polls the UART control register for write space
// (WSPACE), tracks the remaining space as a local credit, and issues data or
// control writes while honouring waitrequest.
//
//   state | meaning
//   IDLE  | bus idle; choose the next transaction from the FIFO head and credit
//   POLL  | read UART control register (address 1) to refresh credit
//   WRITE | write FIFO head to data (address 0) or control (address 1) register
module processor_jtag_bridge_fifo #(
  parameter int          DATA_W     = 16,
  parameter int          SEL_BIT    = 8,
  parameter int          DEPTH      = 16,
  parameter logic [31:0] CTRL_VALUE = 32'd2,
  parameter int          CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              proc_oEn,
  input  logic [DATA_W-1:0] proc_oData,
  output logic              proc_full,
  output logic [CNT_W-1:0]  drop_count,
  output logic              chipselect,
  output logic              address,
  output logic              write_n,
  output logic              read_n,
  output logic [31:0]       writedata,
  input  logic [31:0]       readdata,
  input  logic              waitrequest
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POLL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t        state;
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   credit;

  logic       push;
  logic       pop;
  logic       full_now;
  logic [8:0] head;
  logic       head_sel;

  // Space is judged on the count at the start of the cycle, so a pop never
  // makes room for a push in the same cycle.
  assign full_now = (count == DEPTH_CNT);
  assign push     = proc_oEn && !full_now;
  assign pop      = (state == WRITE) && !waitrequest;
  assign head     = mem[rd_ptr];
  assign head_sel = head[8];

  // FIFO storage: entry is {register select, character}.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {proc_oData[SEL_BIT], proc_oData[7:0]};
    end
  end

  // FIFO pointers, occupancy and the registered full flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      proc_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10: begin
          count     <= count + 1'b1;
          proc_full <= ((count + 1'b1) == DEPTH_CNT);
        end
        2'b01: begin
          count     <= count - 1'b1;
          proc_full <= 1'b0;
        end
        default: proc_full <= full_now;
      endcase
    end
  end

  // Saturating count of strobes lost while the FIFO was full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (proc_oEn && full_now && (drop_count != {CNT_W{1'b1}})) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  // Bus sequencer: a control write needs no credit, a data write spends one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      credit <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            if (head_sel || (credit != '0)) state <= WRITE;
            else                            state <= POLL;
          end
        end
        POLL: begin
          if (!waitrequest) begin
            credit <= readdata[31:16];
            state  <= IDLE;
          end
        end
        WRITE: begin
          if (!waitrequest) begin
            if (!head_sel) credit <= credit - 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus decode from the state register and FIFO head only; the head cannot
  // change during WRITE, so the outputs hold steady through a stall.
  assign chipselect = (state == POLL) || (state == WRITE);
  assign read_n     = (state != POLL);
  assign write_n    = (state != WRITE);
  assign address    = (state == POLL) || ((state == WRITE) && head_sel);
  assign writedata  = (state != WRITE) ? 32'd0 :
                      head_sel         ? CTRL_VALUE : {24'd0, head[7:0]};

endmodule

// File: tb/tb_processor_jtag_bridge_fifo.sv
// Self-checking bench for processor_jtag_bridge_fifo: a queue/credit model of
// the bridge checked every cycle, plus directed scenarios with literal results.
module tb_processor_jtag_bridge_fifo;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        proc_oEn = 1'b0;
  logic [15:0] proc_oData = '0;
  logic        proc_full;
  logic [7:0]  drop_count;
  logic        chipselect, address, write_n, read_n;
  logic [31:0] writedata;
  logic [31:0] readdata = '0;
  logic        waitrequest = 1'b0;

  processor_jtag_bridge_fifo #(
    .DATA_W(16), .SEL_BIT(8), .DEPTH(DEPTH), .CTRL_VALUE(32'd2), .CNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .proc_oEn(proc_oEn), .proc_oData(proc_oData),
    .proc_full(proc_full), .drop_count(drop_count), .chipselect(chipselect),
    .address(address), .write_n(write_n), .read_n(read_n), .writedata(writedata),
    .readdata(readdata), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // staged inputs for the next cycle
  logic        n_en = 1'b0;
  logic [15:0] n_data = '0;
  logic        n_wait = 1'b0;
  logic [31:0] n_rd = '0;

  // behavioural model
  logic [8:0]  mq[$];
  int          mcredit = 0;
  int          mdrop = 0;

  // observed completed transactions
  int          log_kind[$];   // 0 = read, 1 = write
  logic        log_addr[$];
  logic [31:0] log_data[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_log();
    log_kind.delete(); log_addr.delete(); log_data.delete();
  endtask

  // One clock: apply staged inputs, advance to just after the edge, update the
  // model with what happened at that edge and check the outputs against it.
  task automatic step();
    logic p_cs, p_rn, p_wn, p_a, p_wait, p_en;
    logic [31:0] p_wd, p_rdd;
    logic [15:0] p_d;
    logic [8:0]  pre_head;
    int          pre_size;
    logic        exp_write;
    proc_oEn = n_en; proc_oData = n_data; waitrequest = n_wait; readdata = n_rd;
    p_cs = chipselect; p_rn = read_n; p_wn = write_n; p_a = address; p_wd = writedata;
    p_wait = n_wait; p_rdd = n_rd; p_en = n_en; p_d = n_data;
    pre_size = mq.size();
    pre_head = (pre_size != 0) ? mq[0] : 9'd0;
    @(posedge clk);
    #1;
    if (p_cs && !p_wait) begin
      if (!p_wn) begin
        log_kind.push_back(1); log_addr.push_back(p_a); log_data.push_back(p_wd);
        if (pre_size == 0) begin
          chk("write_with_empty_model", 32'(pre_size), 32'd1);
        end else begin
          chk("wr_addr", 32'(p_a), 32'(pre_head[8]));
          chk("wr_data", p_wd, pre_head[8] ? 32'd2 : {24'd0, pre_head[7:0]});
          if (!pre_head[8]) begin
            chk("wr_credit_available", 32'(mcredit > 0), 32'd1);
            mcredit--;
          end
          void'(mq.pop_front());
        end
      end else begin
        log_kind.push_back(0); log_addr.push_back(p_a); log_data.push_back(32'd0);
        chk("rd_addr", 32'(p_a), 32'd1);
        mcredit = int'(p_rdd[31:16]);
      end
      chk("idle_gap_cs", 32'(chipselect), 32'd0);
    end else if (p_cs) begin
      chk("stall_stable", {chipselect, read_n, write_n, address, writedata},
          {p_cs, p_rn, p_wn, p_a, p_wd});
    end else begin
      chk("start_cs", 32'(chipselect), 32'(pre_size != 0));
      if (pre_size != 0) begin
        exp_write = pre_head[8] || (mcredit != 0);
        chk("start_kind", {read_n, write_n}, {exp_write, !exp_write});
      end
    end
    if (p_en) begin
      if (pre_size < DEPTH) mq.push_back({p_d[8], p_d[7:0]});
      else if (mdrop < 255) mdrop++;
    end
    chk("proc_full", 32'(proc_full), 32'(mq.size() == DEPTH));
    chk("drop_count", 32'(drop_count), 32'(mdrop));
    chk("rw_exclusive", 32'(read_n | write_n), 32'd1);
  endtask

  task automatic do_reset();
    n_en = 1'b0; n_data = '0; n_wait = 1'b0; n_rd = '0;
    proc_oEn = 1'b0; waitrequest = 1'b0;
    reset_n = 1'b0;
    #2;
    chk("rst_outputs", {chipselect, write_n, read_n, address, writedata},
        {1'b0, 1'b1, 1'b1, 1'b0, 32'd0});
    chk("rst_full_drop", {proc_full, drop_count}, 9'd0);
    mq.delete(); mcredit = 0; mdrop = 0; clear_log();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run_until_log(input int n, input int limit, input string name);
    for (int k = 0; k < limit && log_kind.size() < n; k++) step();
    chk(name, 32'(log_kind.size() >= n), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int writes;
    @(posedge clk);
    #1;

    // Scenario 1: single char, credit 0, WSPACE 64
    do_reset();
    n_rd = {16'd64, 16'h0};
    n_en = 1'b1; n_data = 16'h0041; step();
    n_en = 1'b0; step();
    run_until_log(2, 20, "s1_timeout");
    if (log_kind.size() >= 2) begin
      chk("s1_poll", {log_kind[0][0], log_addr[0]}, 2'b01);
      chk("s1_write", {log_kind[1][0], log_addr[1], log_data[1]}, {2'b10, 32'h00000041});
    end
    chk("s1_credit", 32'(mcredit), 32'd63);

    // Scenario 2: 'A','B','C' with WSPACE 2 -> re-poll before 'C'
    do_reset();
    n_rd = {16'd2, 16'h0};
    n_en = 1'b1;
    n_data = 16'h0041; step();
    n_data = 16'h0042; step();
    n_data = 16'h0043; step();
    n_en = 1'b0;
    run_until_log(5, 40, "s2_timeout");
    if (log_kind.size() >= 5) begin
      chk("s2_kinds", {log_kind[0][0], log_kind[1][0], log_kind[2][0],
                       log_kind[3][0], log_kind[4][0]}, 5'b01101);
      chk("s2_A", log_data[1], 32'h41);
      chk("s2_B", log_data[2], 32'h42);
      chk("s2_C", log_data[4], 32'h43);
    end

    // Scenario 3: control write, no poll at credit 0
    do_reset();
    n_en = 1'b1; n_data = 16'h0100; step();
    n_en = 1'b0;
    run_until_log(1, 20, "s3_timeout");
    if (log_kind.size() >= 1)
      chk("s3_ctrl", {log_kind[0][0], log_addr[0], log_data[0]}, {2'b11, 32'd2});

    // Scenario 4: 5-cycle stall during a control WRITE
    do_reset();
    n_wait = 1'b1;
    n_en = 1'b1; n_data = 16'h0105; step();
    n_en = 1'b0;
    for (int k = 0; k < 10 && !chipselect; k++) step();
    chk("s4_cs_up", 32'(chipselect), 32'd1);
    for (int k = 0; k < 5; k++) step();
    chk("s4_still_writing", {chipselect, write_n, address, writedata}, {3'b101, 32'd2});
    n_wait = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("s4_one_pop", 32'(log_kind.size()), 32'd1);
    chk("s4_empty", 32'(mq.size()), 32'd0);

    // Scenario 5: overflow with waitrequest stuck high
    do_reset();
    n_wait = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      n_en = 1'b1; n_data = 16'(8'h61 + i); step();
    end
    n_en = 1'b0; step();
    chk("s5_full", 32'(proc_full), 32'd1);
    chk("s5_drops", 32'(drop_count), 32'd3);
    n_wait = 1'b0; n_rd = {16'd64, 16'h0};
    writes = 0;
    for (int k = 0; k < 200 && writes < DEPTH; k++) begin
      step();
      writes = 0;
      foreach (log_kind[j]) if (log_kind[j] == 1) writes++;
    end
    chk("s5_count", 32'(writes), 32'(DEPTH));
    writes = 0;
    foreach (log_kind[j]) begin
      if (log_kind[j] == 1) begin
        chk("s5_order", log_data[j], 32'(8'h61 + writes));
        writes++;
      end
    end
    for (int k = 0; k < 5; k++) step();
    chk("s5_no_extra", 32'(log_kind.size()), 32'(DEPTH + 1));

    // Scenario 6: reset pulsed mid-WRITE
    do_reset();
    n_wait = 1'b1;
    n_en = 1'b1; n_data = 16'h0100; step();
    n_en = 1'b0;
    for (int k = 0; k < 10 && write_n; k++) step();
    chk("s6_in_write", {chipselect, write_n}, 2'b10);
    reset_n = 1'b0;
    #1;
    chk("s6_async_drop", {chipselect, write_n}, 2'b01);
    do_reset();
    n_rd = {16'd5, 16'h0};
    n_en = 1'b1; n_data = 16'h0043; step();
    n_en = 1'b0;
    run_until_log(2, 20, "s6_timeout");
    if (log_kind.size() >= 2) begin
      chk("s6_fresh_poll", {log_kind[0][0], log_addr[0]}, 2'b01);
      chk("s6_write", {log_kind[1][0], log_data[1]}, {1'b1, 32'h43});
    end

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      n_en   = ($urandom_range(0, 2) == 0);
      n_data = 16'($urandom);
      n_data[8] = ($urandom_range(0, 3) == 0);
      n_wait = ($urandom_range(0, 2) == 0);
      n_rd   = {16'($urandom_range(0, 3)), 16'($urandom)};
      step();
    end
    n_en = 1'b0; n_wait = 1'b0; n_rd = {16'd8, 16'h0};
    for (int k = 0; k < 200 && (mq.size() != 0 || chipselect); k++) step();
    chk("rand_drained", 32'(mq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
